lcd_cmd_feeder: RTL and testbench

- Upstream stage of the LCD controller. Buffers host commands in a small FIFO and issues them one at a time on the controller's cmd/cmd_valid/busy handshake.
- For LOAD (cmd 0), streams the 108-byte 12x9 image from a synchronous image ROM onto datain, cycle-aligned with the controller's capture window.
- Guarantees that no command is issued while the controller is processing one.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_cmd_feeder_if.sv | 29 ++
 rtl/lcd_cmd_feeder_fifo.sv | 51 +++++
 rtl/lcd_cmd_feeder.sv | 112 +++++++++++
 tb/tb_lcd_cmd_feeder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: command codes, image geometry and the
// feeder FSM state type.
package lcd_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_LOAD        = 4'd0,
    CMD_WRITE       = 4'd1,
    CMD_ZOOM_IN     = 4'd2,
    CMD_ZOOM_FIT    = 4'd3,
    CMD_SHIFT_RIGHT = 4'd4,
    CMD_SHIFT_LEFT  = 4'd5,
    CMD_SHIFT_UP    = 4'd6,
    CMD_AVERAGE     = 4'd7,
    CMD_SHIFT_DOWN  = 4'd8
  } lcd_cmd_e;

  localparam logic [CMD_W-1:0] CMD_MAX = 4'd8;

  localparam int unsigned IMG_W     = 12;
  localparam int unsigned IMG_H     = 9;
  localparam int unsigned IMG_BYTES = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO
  } feeder_state_e;

endpackage

// File: rtl/lcd_cmd_feeder_if.sv
// Host, image-ROM and controller handshake signals of the command feeder.
interface lcd_cmd_feeder_if
  import lcd_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
);
  logic [CMD_W-1:0]  host_cmd;
  logic              host_valid;
  logic              host_ready;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_valid;
  logic [DATA_W-1:0] datain;
  logic              busy;
  logic              cmd_err;
  logic              idle;

  modport master (
    input  host_cmd, host_valid, rom_data, busy,
    output host_ready, rom_rd, rom_addr, cmd, cmd_valid, datain, cmd_err, idle
  );

  modport slave (
    output host_cmd, host_valid, rom_data, busy,
    input  host_ready, rom_rd, rom_addr, cmd, cmd_valid, datain, cmd_err, idle
  );
endinterface

// File: rtl/lcd_cmd_feeder_fifo.sv
// Host command FIFO: power-of-two depth, first-word fall-through head.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [CMD_W-1:0] data_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok_c, pop_ok_c;

  assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok_c = push_i && !full_o;
  assign pop_ok_c  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lcd_cmd_feeder.sv
// Issues buffered host commands one at a time to the LCD controller and
// streams the LOAD image from ROM aligned with the controller capture window.
module lcd_cmd_feeder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMG_BYTES  = lcd_pkg::IMG_BYTES,
  parameter int unsigned ADDR_W     = 7
) (
  input logic              clk,
  input logic              reset,
  lcd_cmd_feeder_if.master bus
);
  localparam int unsigned CW = lcd_pkg::CMD_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

  lcd_pkg::feeder_state_e state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [CW-1:0]     cmd_q, cmd_d;
  logic              rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              cmd_err_q, cmd_err_d;

  logic          push_c, pop_c, full_c, empty_c;
  logic [CW-1:0] head_c;

  lcd_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .data_i  (bus.host_cmd),
    .pop_i   (pop_c),
    .data_o  (head_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  assign push_c         = bus.host_valid && !full_c;
  assign bus.host_ready = !full_c;
  assign bus.idle       = (state_q == lcd_pkg::ST_IDLE) && empty_c;
  assign bus.datain     = bus.rom_data;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd        = cmd_q;
  assign bus.rom_rd     = rom_rd_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.cmd_err    = cmd_err_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    cmd_err_d   = 1'b0;
    rom_rd_d    = rom_rd_q;
    rom_addr_d  = rom_addr_q;
    pop_c       = 1'b0;

    // Image stream runs on its own once started and parks on the last byte.
    if (rom_rd_q) begin
      if (rom_addr_q == LAST_ADDR) rom_rd_d = 1'b0;
      else                         rom_addr_d = rom_addr_q + ADDR_W'(1);
    end

    case (state_q)
      lcd_pkg::ST_IDLE: begin
        if (!empty_c && !bus.busy) begin
          pop_c = 1'b1;
          if (head_c > lcd_pkg::CMD_MAX) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d     = lcd_pkg::ST_ISSUE;
            cmd_valid_d = 1'b1;
            cmd_d       = head_c;
            if (head_c == lcd_pkg::CMD_LOAD) begin
              rom_rd_d   = 1'b1;
              rom_addr_d = '0;
            end
          end
        end
      end
      lcd_pkg::ST_ISSUE: state_d = lcd_pkg::ST_WAIT_HI;
      lcd_pkg::ST_WAIT_HI: begin
        // Controller must have raised busy by now; otherwise the command was lost.
        if (bus.busy) begin
          state_d = lcd_pkg::ST_WAIT_LO;
        end else begin
          state_d   = lcd_pkg::ST_IDLE;
          cmd_err_d = 1'b1;
        end
      end
      lcd_pkg::ST_WAIT_LO: if (!bus.busy) state_d = lcd_pkg::ST_IDLE;
      default: state_d = lcd_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= lcd_pkg::ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// Randomized bench for lcd_cmd_feeder against a behavioural ROM, controller
// and an ordered-command/error-count reference model.
module tb_lcd_cmd_feeder;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ADDR_W     = 7;
  localparam int          NBYTES     = 108;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_cmd_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  lcd_cmd_feeder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .IMG_BYTES  (NBYTES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Image ROM: byte k holds k+1, one cycle read latency.
  always @(posedge clk) begin
    if (bus.rom_rd) bus.rom_data <= 8'(bus.rom_addr + 7'd1);
  end

  // Behavioural controller: busy the cycle after cmd_valid, captures a LOAD image.
  int mute_budget = 0;
  int muted_seen  = 0;
  int busy_cnt;
  int cap_idx;
  logic capturing;
  logic [7:0] cap_buf [NBYTES];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy  <= 1'b0;
      busy_cnt  <= 0;
      capturing <= 1'b0;
      cap_idx   <= 0;
    end else begin
      if (capturing) begin
        cap_buf[cap_idx] <= bus.datain;
        cap_idx <= cap_idx + 1;
        if (cap_idx == NBYTES - 1) capturing <= 1'b0;
      end
      if (bus.cmd_valid && muted_seen < mute_budget) begin
        muted_seen <= muted_seen + 1;
      end else if (bus.cmd_valid) begin
        bus.busy <= 1'b1;
        if (bus.cmd == 4'd0) begin
          capturing <= 1'b1;
          cap_idx   <= 0;
          busy_cnt  <= NBYTES + 2;
        end else begin
          busy_cnt <= int'($urandom_range(1, 5));
        end
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else if (busy_cnt == 1) begin
        busy_cnt <= 0;
        bus.busy <= 1'b0;
      end
    end
  end

  // Monitor: logs issued commands, error pulses and protocol violations.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int iss_q[$];
  int iss_t[$];
  int err_t[$];
  int rd_cnt = 0, addr_bad = 0, busy_viol = 0, gap_viol = 0;
  int load_t = 0, last_cv = -100;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cmd_valid) begin
        iss_q.push_back(int'(bus.cmd));
        iss_t.push_back(cyc);
        if (bus.busy) busy_viol++;
        if (cyc - last_cv < 3) gap_viol++;
        last_cv = cyc;
        if (bus.cmd == 4'd0) load_t = cyc;
      end
      if (bus.rom_rd) begin
        rd_cnt++;
        if (bus.rom_addr !== 7'(cyc - load_t)) addr_bad++;
      end
      if (bus.cmd_err) err_t.push_back(cyc);
    end
  end

  // Reference model: legal codes are issued in order, each illegal one costs one error pulse.
  task automatic model(input int codes[$], output int legal[$], output int n_bad);
    legal = {};
    n_bad = 0;
    foreach (codes[i]) begin
      if (codes[i] <= 8) legal.push_back(codes[i]);
      else n_bad++;
    end
  endtask

  task automatic push_seq(input int codes[$], output int first_block);
    first_block = -1;
    @(posedge clk); #1;
    foreach (codes[i]) begin
      int w = 0;
      bus.host_cmd   = 4'(codes[i]);
      bus.host_valid = 1'b1;
      @(negedge clk);
      while (!bus.host_ready) begin
        if (first_block < 0) first_block = i;
        w++;
        if (w > 3000) begin
          chk("push_timeout", 0, 1);
          bus.host_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    bus.host_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int stable = 0;
    int n = 0;
    while (stable < 3) begin
      @(negedge clk);
      n++;
      if (bus.idle && !bus.busy) stable++;
      else stable = 0;
      if (n > 5000) begin
        chk("idle_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic check_issues(input string tag, input int base, input int exp[$]);
    chk({tag, "_count"}, 32'(iss_q.size() - base), 32'(exp.size()));
    foreach (exp[i]) begin
      if (base + i < iss_q.size())
        chk($sformatf("%s_cmd%0d", tag, i), 32'(iss_q[base + i]), 32'(exp[i]));
    end
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int k = 0; k < NBYTES; k++) if (cap_buf[k] !== 8'(k + 1)) bad++;
    chk({tag, "_img_bad"}, 32'(bad), 0);
    chk({tag, "_img_last"}, 32'(cap_buf[NBYTES-1]), NBYTES);
  endtask

  initial begin
    int codes[$];
    int legal[$];
    int n_bad, fb, b_iss, b_err, b_rd, b_ab, t0, w;

    reset          = 1'b1;
    bus.host_valid = 1'b0;
    bus.host_cmd   = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_cmd", 32'(bus.cmd), 0);
    chk("rst_rom_rd", 32'(bus.rom_rd), 0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_cmd_err", 32'(bus.cmd_err), 0);
    chk("rst_host_ready", 32'(bus.host_ready), 1);
    chk("rst_idle", 32'(bus.idle), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.idle), 1);

    // Single LOAD
    b_iss = iss_q.size(); b_err = err_t.size(); b_rd = rd_cnt; b_ab = addr_bad;
    push_seq('{0}, fb);
    wait_idle();
    check_issues("load1", b_iss, '{0});
    chk("load1_rd_cycles", 32'(rd_cnt - b_rd), NBYTES);
    chk("load1_addr_bad", 32'(addr_bad - b_ab), 0);
    chk("load1_err", 32'(err_t.size() - b_err), 0);
    chk("load1_addr_park", 32'(bus.rom_addr), NBYTES - 1);
    check_image("load1");

    // Back-to-back sequence
    b_iss = iss_q.size(); b_err = err_t.size();
    push_seq('{0, 3, 5, 1, 4}, fb);
    wait_idle();
    check_issues("seq5", b_iss, '{0, 3, 5, 1, 4});
    chk("seq5_err", 32'(err_t.size() - b_err), 0);

    // Fill FIFO while a LOAD holds the controller busy
    b_iss = iss_q.size();
    push_seq('{0}, fb);
    w = 0;
    while (!bus.busy && w < 50) begin @(negedge clk); w++; end
    chk("fill_busy_seen", 32'(bus.busy), 1);
    codes = {};
    for (int i = 0; i < FIFO_DEPTH + 2; i++) codes.push_back(int'($urandom_range(0, 8)));
    push_seq(codes, fb);
    chk("fill_accept_before_full", 32'(fb), FIFO_DEPTH);
    wait_idle();
    codes.push_front(0);
    check_issues("fill", b_iss, codes);

    // Illegal code followed by a legal one
    b_iss = iss_q.size(); b_err = err_t.size();
    push_seq('{9, 2}, fb);
    wait_idle();
    check_issues("bad9", b_iss, '{2});
    chk("bad9_err", 32'(err_t.size() - b_err), 1);
    if (err_t.size() > b_err && iss_q.size() > b_iss)
      chk("bad9_err_first", 32'(err_t[b_err] < iss_t[b_iss]), 1);

    // Randomized mixes of legal, LOAD and illegal codes
    for (int r = 0; r < 3; r++) begin
      codes = {};
      for (int i = 0; i < 10; i++) begin
        int p = int'($urandom_range(0, 9));
        if (p < 1) codes.push_back(0);
        else if (p < 8) codes.push_back(int'($urandom_range(1, 8)));
        else codes.push_back(int'($urandom_range(9, 15)));
      end
      model(codes, legal, n_bad);
      b_iss = iss_q.size(); b_err = err_t.size();
      push_seq(codes, fb);
      wait_idle();
      check_issues($sformatf("rnd%0d", r), b_iss, legal);
      chk($sformatf("rnd%0d_err", r), 32'(err_t.size() - b_err), 32'(n_bad));
    end

    // Lost command: controller ignores the first strobe
    b_iss = iss_q.size(); b_err = err_t.size();
    mute_budget = muted_seen + 1;
    push_seq('{3, 5}, fb);
    wait_idle();
    check_issues("lost", b_iss, '{3, 5});
    chk("lost_err", 32'(err_t.size() - b_err), 1);
    if (err_t.size() > b_err && iss_t.size() > b_iss + 1) begin
      chk("lost_err_at_T2", 32'(err_t[b_err] - iss_t[b_iss]), 2);
      chk("lost_next_at_T3", 32'(iss_t[b_iss + 1] - iss_t[b_iss]), 3);
    end

    // Reset in the middle of a LOAD
    push_seq('{0}, fb);
    w = 0;
    @(negedge clk);
    while (!bus.cmd_valid && w < 50) begin @(negedge clk); w++; end
    chk("midrst_load_seen", 32'(bus.cmd_valid), 1);
    t0 = cyc;
    repeat (50) @(negedge clk);
    chk("midrst_addr_T50", 32'(bus.rom_addr), 50);
    chk("midrst_rd_T50", 32'(bus.rom_rd), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_rom_rd", 32'(bus.rom_rd), 0);
    chk("midrst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("midrst_host_ready", 32'(bus.host_ready), 1);
    chk("midrst_idle", 32'(bus.idle), 1);
    chk("midrst_rom_addr", 32'(bus.rom_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b_iss = iss_q.size(); b_rd = rd_cnt; b_ab = addr_bad; b_err = err_t.size();
    push_seq('{0}, fb);
    wait_idle();
    check_issues("reload", b_iss, '{0});
    chk("reload_rd_cycles", 32'(rd_cnt - b_rd), NBYTES);
    chk("reload_addr_bad", 32'(addr_bad - b_ab), 0);
    chk("reload_err", 32'(err_t.size() - b_err), 0);
    check_image("reload");

    chk("no_cmd_while_busy", 32'(busy_viol), 0);
    chk("cmd_spacing", 32'(gap_viol), 0);
    chk("sim_cycles_sane", 32'(cyc > t0), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
